// File: rtl/bus_master_rr.sv
// bus_master_rr: multi-port word-access master. A round-robin arbiter picks one
// pending client request at a time and drives it onto a single Avalon-MM master,
// with an optional wait-state timeout that aborts a stalled access.
module bus_master_rr #(
  parameter int unsigned PORTS   = 2,
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PORTS*ADDR_W-1:0] port_addr,
  input  logic [PORTS*DATA_W-1:0] port_data_wr,
  input  logic [PORTS-1:0]        port_write,
  input  logic [PORTS-1:0]        port_start,
  output logic [PORTS*DATA_W-1:0] port_data_rd,
  output logic [PORTS-1:0]        port_ready,
  output logic [PORTS-1:0]        port_err,
  output logic [31:0]             avl_address,
  output logic                    avl_read,
  output logic                    avl_write,
  output logic [DATA_W-1:0]       avl_writedata,
  output logic [DATA_W/8-1:0]     avl_byteenable,
  input  logic [DATA_W-1:0]       avl_readdata,
  input  logic                    avl_waitrequest
);

  localparam int unsigned IdxW = (PORTS > 1) ? $clog2(PORTS) : 1;
  // With the timeout disabled the counter is a harmless 1-bit stub.
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT);
  localparam logic [IdxW-1:0] LastPort = IdxW'(PORTS - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e state_q, state_d;

  // Per-port request registers
  logic [PORTS-1:0]        pend_q, pend_d, pend_clr;
  logic [PORTS*ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [PORTS*DATA_W-1:0] req_data_q, req_data_d;
  logic [PORTS-1:0]        req_write_q, req_write_d;

  // Arbitration and access tracking
  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            sel_valid;
  logic [IdxW-1:0] sel_idx;

  // Registered outputs
  logic [31:0]             avl_address_q, avl_address_d;
  logic                    avl_read_q, avl_read_d;
  logic                    avl_write_q, avl_write_d;
  logic [DATA_W-1:0]       avl_writedata_q, avl_writedata_d;
  logic [PORTS-1:0]        ready_q, ready_d;
  logic [PORTS-1:0]        err_q, err_d;
  logic [PORTS*DATA_W-1:0] data_rd_q, data_rd_d;

  // Capture a start on a free port; a port being retired this cycle counts as free.
  always_comb begin
    pend_d      = pend_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_write_d = req_write_q;
    for (int i = 0; i < PORTS; i++) begin
      if (pend_clr[i]) begin
        pend_d[i] = 1'b0;
      end
      if (port_start[i] && (!pend_q[i] || pend_clr[i])) begin
        pend_d[i]                        = 1'b1;
        req_addr_d[i*ADDR_W +: ADDR_W]   = port_addr[i*ADDR_W +: ADDR_W];
        req_data_d[i*DATA_W +: DATA_W]   = port_data_wr[i*DATA_W +: DATA_W];
        req_write_d[i]                   = port_write[i];
      end
    end
  end

  // Round-robin pick: first pending port at or after the priority pointer.
  always_comb begin : arb
    int unsigned cand;
    cand      = 0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      cand = (32'(rr_q) + k) % PORTS;
      if (!sel_valid && pend_q[IdxW'(cand)]) begin
        sel_valid = 1'b1;
        sel_idx   = IdxW'(cand);
      end
    end
  end

  // FSM next-state, Avalon drive, completion and wait-state timeout.
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    rr_d            = rr_q;
    wait_cnt_d      = wait_cnt_q;
    avl_address_d   = avl_address_q;
    avl_read_d      = avl_read_q;
    avl_write_d     = avl_write_q;
    avl_writedata_d = avl_writedata_q;
    ready_d         = '0;
    err_d           = '0;
    data_rd_d       = data_rd_q;
    pend_clr        = '0;

    case (state_q)
      StIdle: begin
        if (sel_valid) begin
          grant_d         = sel_idx;
          avl_address_d   = 32'({req_addr_q[sel_idx*ADDR_W +: ADDR_W], 2'b00});
          avl_writedata_d = req_data_q[sel_idx*DATA_W +: DATA_W];
          avl_read_d      = ~req_write_q[sel_idx];
          avl_write_d     = req_write_q[sel_idx];
          wait_cnt_d      = '0;
          state_d         = StAccess;
        end
      end
      StAccess: begin
        if (!avl_waitrequest) begin
          avl_read_d  = 1'b0;
          avl_write_d = 1'b0;
          if (avl_read_q) begin
            data_rd_d[grant_q*DATA_W +: DATA_W] = avl_readdata;
          end
          ready_d[grant_q] = 1'b1;
          state_d          = StDone;
        end else if ((TIMEOUT != 0) && (wait_cnt_q == CntLimit)) begin
          avl_read_d       = 1'b0;
          avl_write_d      = 1'b0;
          ready_d[grant_q] = 1'b1;
          err_d[grant_q]   = 1'b1;
          state_d          = StDone;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StDone: begin
        // ready is visible this cycle; retire the request and rotate priority
        pend_clr[grant_q] = 1'b1;
        rr_d              = (grant_q == LastPort) ? '0 : grant_q + 1'b1;
        state_d           = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      pend_q          <= '0;
      req_addr_q      <= '0;
      req_data_q      <= '0;
      req_write_q     <= '0;
      rr_q            <= '0;
      grant_q         <= '0;
      wait_cnt_q      <= '0;
      avl_address_q   <= '0;
      avl_read_q      <= 1'b0;
      avl_write_q     <= 1'b0;
      avl_writedata_q <= '0;
      ready_q         <= '0;
      err_q           <= '0;
      data_rd_q       <= '0;
    end else begin
      state_q         <= state_d;
      pend_q          <= pend_d;
      req_addr_q      <= req_addr_d;
      req_data_q      <= req_data_d;
      req_write_q     <= req_write_d;
      rr_q            <= rr_d;
      grant_q         <= grant_d;
      wait_cnt_q      <= wait_cnt_d;
      avl_address_q   <= avl_address_d;
      avl_read_q      <= avl_read_d;
      avl_write_q     <= avl_write_d;
      avl_writedata_q <= avl_writedata_d;
      ready_q         <= ready_d;
      err_q           <= err_d;
      data_rd_q       <= data_rd_d;
    end
  end

  assign port_data_rd   = data_rd_q;
  assign port_ready     = ready_q;
  assign port_err       = err_q;
  assign avl_address    = avl_address_q;
  assign avl_read       = avl_read_q;
  assign avl_write      = avl_write_q;
  assign avl_writedata  = avl_writedata_q;
  assign avl_byteenable = '1;

endmodule

// File: tb/tb_bus_master_rr.sv
// Scoreboard bench for bus_master_rr: 4 ports, timeout of 4 wait states.
module tb_bus_master_rr;

  localparam int P = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [P*30-1:0] port_addr;
  logic [P*32-1:0] port_data_wr;
  logic [P-1:0]    port_write;
  logic [P-1:0]    port_start;
  logic [P*32-1:0] port_data_rd;
  logic [P-1:0]    port_ready;
  logic [P-1:0]    port_err;
  logic [31:0]     avl_address;
  logic            avl_read;
  logic            avl_write;
  logic [31:0]     avl_writedata;
  logic [3:0]      avl_byteenable;
  logic [31:0]     avl_readdata;
  logic            avl_waitrequest;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wait_cycles = 0;
  int acc_cnt = 0;
  int base;

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          len;    // 0: length not checked
  } acc_t;

  exp_t exp_q[$];
  acc_t acc_q[$];

  bus_master_rr #(
    .PORTS  (P),
    .ADDR_W (30),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .port_addr      (port_addr),
    .port_data_wr   (port_data_wr),
    .port_write     (port_write),
    .port_start     (port_start),
    .port_data_rd   (port_data_rd),
    .port_ready     (port_ready),
    .port_err       (port_err),
    .avl_address    (avl_address),
    .avl_read       (avl_read),
    .avl_write      (avl_write),
    .avl_writedata  (avl_writedata),
    .avl_byteenable (avl_byteenable),
    .avl_readdata   (avl_readdata),
    .avl_waitrequest(avl_waitrequest)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: byte address 0xF000_0000 and up never answers; elsewhere
  // waitrequest is held for the first wait_cycles cycles of each access.
  always @(posedge clk) acc_cnt <= (avl_read || avl_write) ? acc_cnt + 1 : 0;
  assign avl_waitrequest = (avl_read || avl_write) &&
                           ((avl_address[31:28] == 4'hF) || (acc_cnt < wait_cycles));
  assign avl_readdata = (avl_address == 32'h40) ? 32'hDEADBEEF : (avl_address ^ 32'h12345678);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(port_ready), 64'd0);
    check({tag, "_err"}, 64'(port_err), 64'd0);
    check({tag, "_data_rd_lo"}, port_data_rd[63:0], 64'd0);
    check({tag, "_data_rd_hi"}, port_data_rd[127:64], 64'd0);
    check({tag, "_avl_read"}, 64'(avl_read), 64'd0);
    check({tag, "_avl_write"}, 64'(avl_write), 64'd0);
    check({tag, "_avl_address"}, 64'(avl_address), 64'd0);
    check({tag, "_avl_writedata"}, 64'(avl_writedata), 64'd0);
  endtask

  task automatic set_req(input int p, input logic wr, input logic [29:0] a, input logic [31:0] d);
    port_start[p]          = 1'b1;
    port_write[p]          = wr;
    port_addr[p*30 +: 30]  = a;
    port_data_wr[p*32 +: 32] = d;
  endtask

  task automatic push_exp(input int p, input logic err, input logic [31:0] d, input int c);
    exp_t e;
    e.port = p; e.err = err; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic push_acc(input logic [31:0] a, input logic wr, input logic [31:0] wd, input int len);
    acc_t x;
    x.addr = a; x.wr = wr; x.wdata = wd; x.len = len;
    acc_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    port_start = '0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || acc_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || acc_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d responses and %0d accesses outstanding, required 0",
               exp_q.size(), acc_q.size());
      exp_q.delete();
      acc_q.delete();
    end
    repeat (2) tick();
  endtask

  // Response monitor: every ready pulse is matched against the head of exp_q.
  always @(negedge clk) begin
    exp_t e;
    if ($countones(port_ready) > 1) begin
      checks++;
      failures++;
      $display("FAIL ready_onehot: got %b, required at most one bit", port_ready);
    end
    for (int i = 0; i < P; i++) begin
      if (port_ready[i]) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ready: got ready on port %0d at cycle %0d, required none",
                   i, cyc);
        end else begin
          e = exp_q.pop_front();
          check("ready_port", 64'(i), 64'(e.port));
          check("ready_cycle", 64'(cyc), 64'(e.cyc));
          check("ready_err", 64'(port_err[i]), 64'(e.err));
          check("data_rd", 64'(port_data_rd[i*32 +: 32]), 64'(e.data));
        end
      end
    end
    if ((port_err & ~port_ready) != '0) begin
      checks++;
      failures++;
      $display("FAIL err_without_ready: got err=%b ready=%b", port_err, port_ready);
    end
  end

  // Avalon monitor: checks each access on entry, address stability and duration.
  logic        act_prev = 1'b0;
  int          act_len = 0;
  int          cur_len = 0;
  logic [31:0] hold_addr = '0;

  always @(negedge clk) begin
    acc_t a;
    if (avl_read || avl_write) begin
      if (!act_prev) begin
        if (acc_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_access: got access at 0x%0h cycle %0d, required none",
                   avl_address, cyc);
          cur_len <= 0;
        end else begin
          a = acc_q.pop_front();
          check("avl_address", 64'(avl_address), 64'(a.addr));
          check("avl_write", 64'(avl_write), 64'(a.wr));
          check("avl_read", 64'(avl_read), 64'(!a.wr));
          if (a.wr) check("avl_writedata", 64'(avl_writedata), 64'(a.wdata));
          check("avl_byteenable", 64'(avl_byteenable), 64'hF);
          cur_len <= a.len;
        end
        act_len   <= 1;
        hold_addr <= avl_address;
      end else begin
        act_len <= act_len + 1;
        check("avl_addr_stable", 64'(avl_address), 64'(hold_addr));
      end
    end else if (act_prev && cur_len > 0) begin
      check("avl_active_len", 64'(act_len), 64'(cur_len));
    end
    act_prev <= avl_read || avl_write;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int restarts;
    logic [31:0] rr_data [4];
    rr_data[0] = 32'h12345278;  // 0x400 ^ 0x12345678
    rr_data[1] = 32'h1234527C;  // 0x404
    rr_data[2] = 32'h12345270;  // 0x408
    rr_data[3] = 32'h12345274;  // 0x40C

    rst_n        = 1'b0;
    port_addr    = '0;
    port_data_wr = '0;
    port_write   = '0;
    port_start   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Simultaneous starts after reset: port 0 write, port 3 read, 0 first.
    base = cyc;
    set_req(0, 1'b1, 30'h5, 32'h11);
    set_req(3, 1'b0, 30'h20, 32'h0);
    push_acc(32'h14, 1'b1, 32'h11, 1);
    push_exp(0, 1'b0, 32'h0, base + 3);
    push_acc(32'h80, 1'b0, 32'h0, 1);
    push_exp(3, 1'b0, 32'h123456F8, base + 6);
    tick();
    wait_idle(40);

    // rr wrapped to 0: same order again; port 0 single read at 0x10.
    base = cyc;
    set_req(0, 1'b0, 30'h10, 32'h0);
    set_req(3, 1'b1, 30'h21, 32'hCAFEF00D);
    push_acc(32'h40, 1'b0, 32'h0, 1);
    push_exp(0, 1'b0, 32'hDEADBEEF, base + 3);
    push_acc(32'h84, 1'b1, 32'hCAFEF00D, 1);
    push_exp(3, 1'b0, 32'h123456F8, base + 6);
    tick();
    wait_idle(40);

    // Round robin: all ports read, each restarts in the cycle of its ready.
    base = cyc;
    for (int i = 0; i < P; i++) set_req(i, 1'b0, 30'(32'h100 + i), 32'h0);
    for (int k = 0; k < 8; k++) begin
      push_acc(32'h400 + 32'(4 * (k % 4)), 1'b0, 32'h0, 1);
      push_exp(k % 4, 1'b0, rr_data[k % 4], base + 3 + 3 * k);
    end
    seen     = 0;
    restarts = 0;
    for (int c = 0; c < 60 && seen < 8; c++) begin
      tick();
      @(negedge clk);
      for (int i = 0; i < P; i++) begin
        if (port_ready[i]) begin
          seen++;
          if (restarts < 4) begin
            port_start[i] = 1'b1;
            restarts++;
          end
        end
      end
    end
    port_start = '0;
    check("rr_ready_count", 64'(seen), 64'd8);
    wait_idle(40);

    // Four wait states: just under the timeout, so the read succeeds.
    wait_cycles = 4;
    base = cyc;
    set_req(1, 1'b0, 30'h30, 32'h0);
    push_acc(32'hC0, 1'b0, 32'h0, 5);
    push_exp(1, 1'b0, 32'h123456B8, base + 7);
    tick();
    wait_idle(40);
    wait_cycles = 0;

    // Timeout: port 2 hits a dead address, port 3 write is granted next.
    base = cyc;
    set_req(2, 1'b0, 30'h3C000000, 32'h0);
    set_req(3, 1'b1, 30'h22, 32'h55AA55AA);
    push_acc(32'hF0000000, 1'b0, 32'h0, 5);
    push_exp(2, 1'b1, 32'h12345270, base + 7);
    push_acc(32'h88, 1'b1, 32'h55AA55AA, 1);
    push_exp(3, 1'b0, 32'h12345274, base + 10);
    tick();
    wait_idle(40);

    // Second start on a pending port is dropped.
    wait_cycles = 2;
    base = cyc;
    set_req(1, 1'b0, 30'h40, 32'h0);
    push_acc(32'h100, 1'b0, 32'h0, 3);
    push_exp(1, 1'b0, 32'h12345778, base + 5);
    tick();
    set_req(1, 1'b0, 30'h41, 32'h0);
    tick();
    wait_idle(40);
    repeat (6) tick();

    // Reset during a stalled access: everything pending is lost.
    wait_cycles = 100;
    set_req(0, 1'b0, 30'h50, 32'h0);
    set_req(1, 1'b0, 30'h51, 32'h0);
    push_acc(32'h140, 1'b0, 32'h0, 0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("pre_reset_avl_read", 64'(avl_read), 64'd1);
    @(negedge clk);
    check_all_zero("mid_reset");
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    wait_cycles = 0;
    repeat (12) tick();
    check("lost_access_queue", 64'(acc_q.size()), 64'd0);

    // Recovery after reset: rr back to 0, port 2 served normally.
    base = cyc;
    set_req(2, 1'b0, 30'h10, 32'h0);
    push_acc(32'h40, 1'b0, 32'h0, 1);
    push_exp(2, 1'b0, 32'hDEADBEEF, base + 3);
    tick();
    wait_idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_master_rr.md
# bus_master_rr

Parametrised Avalon-MM bus master that serves `PORTS` independent CPU-side request ports through one Avalon master. It generalises the fixed instruction/data two-port master. Each port uses the existing start/ready word-access handshake. A round-robin arbiter with a wait-state timeout selects which port drives the Avalon interface. The block sits between the core (or any number of cores or DMA clients) and `bus_arbiter`.

## Interface
- `PORTS`, 2: number of client request ports (≥1); port index 0..PORTS-1.
- `ADDR_W`, 30: client word-address width; the Avalon byte address is `{port_addr, 2'b00}`, zero-extended to 32 bits.
- `DATA_W`, 32: data width; byteenable width is DATA_W/8.
- `TIMEOUT`, 0: maximum Avalon wait-state cycles before an access is aborted; 0 disables the timeout.

Ports (the `port_*` vectors are packed, with port i at slice `[i*W +: W]`):
- `clk`  in  1  single clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `port_addr`  in  PORTS*ADDR_W  word address, sampled with start.
- `port_data_wr`  in  PORTS*DATA_W  write data, sampled with start.
- `port_write`  in  PORTS  1 = write, 0 = read, sampled with start.
- `port_start`  in  PORTS  one-cycle request strobe.
- `port_data_rd`  out  PORTS*DATA_W  read data, valid from ready until that port's next ready.
- `port_ready`  out  PORTS  one-cycle completion pulse.
- `port_err`  out  PORTS  qualifies ready: 1 = timeout abort.
- `avl_address`  out  32  byte address.
- `avl_read`  out  1  Avalon read.
- `avl_write`  out  1  Avalon write.
- `avl_writedata`  out  DATA_W  write data.
- `avl_byteenable`  out  DATA_W/8  always all ones.
- `avl_readdata`  in  DATA_W  read data.
- `avl_waitrequest`  in  1  Avalon stall.

## Operation
- **Request capture.** A per-port request register (pending, addr, data, write) loads on `port_start[i]` when port i is not pending.
  - A start on an already-pending port is ignored and the request is dropped.
  - A start in the same cycle as that port's `port_ready` is accepted, because pending clears on that edge.
- **FSM states:** IDLE, ACCESS, DONE.
  - IDLE: if any port is pending, grant the first pending port at or after priority pointer `rr`, load the Avalon outputs, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: `avl_read` = ~write or `avl_write` = write. Address and data are held constant.
    - When `avl_waitrequest` = 0, capture `avl_readdata` (reads only), then go to DONE.
    - If `TIMEOUT` ≠ 0 and the wait counter reaches `TIMEOUT` with waitrequest still 1: deassert read/write, set err, then go to DONE.
  - DONE: pulse `port_ready[g]` with `port_err[g]`, clear pending[g], set `rr` = (g+1) mod PORTS, then go to IDLE.
- The wait counter clears on entry to ACCESS and counts cycles with waitrequest = 1. It is `$clog2(TIMEOUT+1)` bits wide and saturates.
- `port_data_rd[g]` updates only on a successful read. Writes and aborts leave it unchanged.
- **Reset values:** all of `port_ready`, `port_err`, `port_data_rd`, `avl_read`, `avl_write`, `avl_address` and `avl_writedata` are 0. Pending is cleared, `rr` = 0, and the FSM is in IDLE.
- **Reset mid-ACCESS:** read/write are 0 the cycle after reset is sampled. No ready is issued and all pending requests are lost.
- **PORTS = 1:** the arbiter degenerates to a pass-through and `rr` stays 0.

## Timing
- Cycle t: start. t+1: pending is visible and IDLE grants. t+2: ACCESS, with avl_read/write asserted. With no wait states, t+3 is DONE and ready pulses.
- Minimum latency from start to ready is 3 cycles. Each wait-state cycle adds 1.
- Throughput is at most one transaction per 3 cycles.
- A timeout abort leaves avl_read/write asserted for exactly `TIMEOUT`+1 cycles. err/ready follow on the next cycle.
- Avalon outputs are registered and stable for the whole ACCESS. No output depends combinationally on any input.

## Test plan
- **Single read, PORTS=2, zero wait.** Port 0 reads addr 0x10 and readdata = 0xDEADBEEF.
  - avl_address = 0x40 and avl_read is high for 1 cycle.
  - port_ready[0] pulses at start+3 with data_rd = 0xDEADBEEF and err = 0.
- **Simultaneous starts after reset.** Port 0 writes 0x11 and port 1 reads.
  - Port 0 is served first, then port 1.
  - The next simultaneous pair is served in order 0, 1 again, because rr wraps to 0 after port 1 completes.
- **Round-robin fairness, PORTS=4.** All ports restart immediately after each ready.
  - Grants cycle 0, 1, 2, 3, 0, … with no port starved.
- **Wait states, TIMEOUT=0.** waitrequest is held high for 5 cycles.
  - avl_read stays high for 6 cycles with address stable. Ready comes at start+8.
- **Timeout, TIMEOUT=4.** waitrequest is held high permanently.
  - avl_read is high for 5 cycles, then port_ready and port_err pulse.
  - data_rd keeps its previous value, and the next pending port is granted.
- **Start while pending, and reset mid-ACCESS.**
  - A second start on a pending port is dropped: exactly one ready is seen.
  - rst_n low during ACCESS: avl_read is 0 the next cycle, with no ready and all outputs 0.
